// File: rtl/acq_pkg.sv
// Shared definitions for the symbol acquisition stage: modulation modes,
// default bit-rate divider and the bits-per-symbol rule.
package acq_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_8PSK  = 2'd2,
        MODE_16QAM = 2'd3
    } acq_mode_e;

    // 50 MHz system clock, 2 kHz bit rate
    localparam int unsigned DIV_DEFAULT = 32'd25000;

    // Bits per symbol is mode+1, limited to the width of the symbol register
    function automatic int unsigned bits_per_symbol(input int unsigned mode_v,
                                                    input int unsigned max_bits);
        int unsigned nb;
        nb = mode_v + 32'd1;
        if (nb > max_bits) begin
            return max_bits;
        end else begin
            return nb;
        end
    endfunction

endpackage

// File: rtl/acq_tick_gen.sv
// Bit-rate clock enable: one-cycle tick every DIV clk cycles while enabled,
// restarting its phase whenever en is low.
module acq_tick_gen #(
    parameter int unsigned DIV = 32'd25000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned    CNT_W  = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DIV - 32'd1);
    localparam logic [CNT_W-1:0] PRE_C  = CNT_W'(DIV - 32'd2);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Counter wraps at DIV-1; tick is registered one cycle early so it is high while cnt_r==DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == LAST_C) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + ONE_C;
            end
            tick_r <= (cnt_r == PRE_C);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/acq_hold_param.sv
// Serial-to-parallel symbol acquisition and hold: collects 1..MAX_BITS bits
// per symbol on bit ticks and holds each completed symbol for the mapper.
module acq_hold_param
    import acq_pkg::*;
#(
    parameter int unsigned MAX_BITS = 32'd4,
    parameter int unsigned DIV      = DIV_DEFAULT,
    parameter int unsigned MODE_W   = 32'd2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [MODE_W-1:0]   mode,
    input  logic                in,
    output logic [MAX_BITS-1:0] sym_out,
    output logic                sym_valid,
    output logic                bit_tick,
    output logic [MODE_W-1:0]   sym_mode
);

    localparam int unsigned      IDX_W   = (MAX_BITS > 32'd1) ? $clog2(MAX_BITS) : 32'd1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(32'd1);

    logic                tick_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    last_idx_s;
    logic [MAX_BITS-1:0] shift_r;
    logic [MAX_BITS-1:0] sym_r;
    logic [MAX_BITS-1:0] packed_s;
    logic [MODE_W-1:0]   cur_mode_r;
    logic [MODE_W-1:0]   mode_s;
    logic [MODE_W-1:0]   sym_mode_r;
    logic                sym_valid_r;

    acq_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick_s)
    );

    // Mode in force: the live input at a symbol start, the latched one afterwards
    always_comb begin
        if (idx_r == {IDX_W{1'b0}}) begin
            mode_s = mode;
        end else begin
            mode_s = cur_mode_r;
        end
        last_idx_s = IDX_W'(bits_per_symbol(32'(mode_s), MAX_BITS) - 32'd1);
    end

    // Completed symbol: collected bits below idx, the current input at idx, zeros above
    always_comb begin
        packed_s = {MAX_BITS{1'b0}};
        for (int i = 0; i < int'(MAX_BITS); i++) begin
            if (i < int'(idx_r)) begin
                packed_s[i] = shift_r[i];
            end else if (i == int'(idx_r)) begin
                packed_s[i] = in;
            end else begin
                packed_s[i] = 1'b0;
            end
        end
    end

    // Symbol assembly and hold; dropping en discards any partial symbol
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r       <= {IDX_W{1'b0}};
            shift_r     <= {MAX_BITS{1'b0}};
            sym_r       <= {MAX_BITS{1'b0}};
            cur_mode_r  <= {MODE_W{1'b0}};
            sym_mode_r  <= {MODE_W{1'b0}};
            sym_valid_r <= 1'b0;
        end else begin
            sym_valid_r <= 1'b0;
            if (!en) begin
                idx_r   <= {IDX_W{1'b0}};
                shift_r <= {MAX_BITS{1'b0}};
            end else if (tick_s) begin
                if (idx_r == {IDX_W{1'b0}}) begin
                    cur_mode_r <= mode;
                end
                if (idx_r == last_idx_s) begin
                    sym_r       <= packed_s;
                    sym_mode_r  <= mode_s;
                    sym_valid_r <= 1'b1;
                    idx_r       <= {IDX_W{1'b0}};
                    shift_r     <= {MAX_BITS{1'b0}};
                end else begin
                    shift_r[idx_r] <= in;
                    idx_r          <= idx_r + IDX_ONE;
                end
            end
        end
    end

    assign sym_out   = sym_r;
    assign sym_valid = sym_valid_r;
    assign bit_tick  = tick_s;
    assign sym_mode  = sym_mode_r;

endmodule

// File: doc/acq_hold_param.md
Name: acq_hold_param

Overview:
- Parametrised serial-to-parallel symbol acquisition and hold stage for the configurable modulator front end.
- Samples a serial bit stream at a programmable bit rate and assembles 1..MAX_BITS bits per symbol, selected by mode (BPSK/QPSK/8PSK/16QAM).
- Holds each completed symbol stable for the mapper for a full symbol period and flags it with a one-cycle valid strobe.
- Bit timing comes from a clock-enable tick, not a derived clock, so the whole block runs on clk.

Parameters:
- MAX_BITS, 4, width of the symbol register; the largest bits-per-symbol supported.
- DIV, 25000, clk cycles per bit tick (50 MHz / 2 kHz); must be >= 2.
- MODE_W, 2, width of mode; bits per symbol = mode + 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  acquisition enable; low = idle and realign.
- mode  input  MODE_W  bits per symbol minus one; sampled only at symbol boundaries.
- in  input  1  serial data bit.
- sym_out  output  MAX_BITS  held symbol; first-received bit in bit 0; unused upper bits are 0.
- sym_valid  output  1  one-clk pulse when sym_out is updated.
- bit_tick  output  1  one-clk pulse at each bit sample instant (debug/sync).
- sym_mode  output  MODE_W  mode that applies to the current sym_out.

Behaviour:
- Reset (rst=0, asynchronous): the tick counter, bit index, shift register, sym_out, sym_valid, bit_tick and sym_mode all go to 0 immediately. Deassertion takes effect at the next clk edge.
- Tick generator:
  - A counter runs 0..DIV-1 while en=1.
  - bit_tick=1 in the cycle where counter==DIV-1; the counter then wraps to 0.
  - en=0 clears the counter to 0, so the first tick comes DIV cycles after en rises.
- Symbol state is an index idx in 0..nbits-1, where nbits = latched mode + 1.
- The active mode is latched into cur_mode at each tick where idx==0. A mode change mid-symbol has no effect until the next symbol starts.
- On a tick with idx==k (k < nbits-1): shift[k] <= in; idx <= k+1.
- On a tick with idx==nbits-1:
  - sym_out <= {shift bits 0..k-1, in at bit k}, with bits above k forced to 0.
  - sym_mode <= cur_mode; sym_valid <= 1 for that single cycle; idx <= 0; shift cleared.
- Latency: sym_out and sym_valid change on the same clk edge that samples the last bit. Both are registered and have no combinational path from in.
- sym_out holds its value between updates, including while en=0.
- en=0 mid-symbol: the partial symbol is discarded, idx goes to 0 and the shift register clears, with no sym_valid. Re-enabling starts a fresh symbol.
- Mode values that give nbits > MAX_BITS are clamped to MAX_BITS.
- mode=0 (1 bit per symbol): every tick produces a sym_valid, and sym_out[0] = in.
- Reset mid-symbol: all state clears at once; no partial symbol is ever emitted.

Decomposition:
- Package acq_pkg holds:
  - Mode constants MODE_BPSK=0, MODE_QPSK=1, MODE_8PSK=2, MODE_16QAM=3.
  - A function giving bits-per-symbol from mode.
  - The default DIV constant.
- Sub-module acq_tick_gen (parameter DIV; ports clk, rst, en, tick) is the natural split. It replaces the old derived-clock divider with a clock enable.

Test Plan:
- Reset check: hold rst=0 with toggling in -> sym_out=0, sym_valid=0, bit_tick=0; after release, the first bit_tick arrives exactly DIV cycles after en=1.
- QPSK packing, DIV=4, mode=1, bit stream 1,0,0,1 -> sym_out=2'b01 then 2'b10 (zero-extended to 4'b0001, 4'b0010), each with a one-cycle sym_valid and sym_valid spaced 8 clk apart.
- 16QAM packing, DIV=4, mode=3, stream 1,1,0,1 -> sym_out=4'b1011 with sym_mode=3 and exactly one sym_valid per 16 clk.
- Mode change mid-symbol: in mode=1, switch to mode=3 after the first bit -> the current symbol completes as 2 bits, and the next symbol collects 4 bits.
- en drop after 2 of 4 bits -> no sym_valid and sym_out keeps its previous value; after en=1 the next 4 bits form a fresh symbol.
- Async reset asserted between ticks mid-symbol -> outputs go to 0 with no clk edge needed; no stale partial symbol appears after release.
